// File: rtl/ddr3_init_refresh_sequencer_if.sv
// Upstream scheduler command channel into the DDR3 init/refresh sequencer.
// The scheduler is the master; the sequencer is the slave and owns cmd_ready.
interface ddr3_init_refresh_sequencer_if #(
    parameter int unsigned ROW_WIDTH  = 13,
    parameter int unsigned BANK_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic [BANK_WIDTH-1:0] ba;
    logic [ROW_WIDTH-1:0]  addr;
    logic                  odt;
    logic                  idle;

    modport master (
        output cmd_valid, ras_n, cas_n, we_n, ba, addr, odt, idle,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, ras_n, cas_n, we_n, ba, addr, odt, idle,
        output cmd_ready
    );
endinterface

// File: rtl/ddr3_init_refresh_sequencer.sv
// Owns the DDR3 command pins: power-up/MRS/ZQCL init, periodic PREA+REF, and a one-cycle
// registered pass-through of upstream commands while idle.
module ddr3_init_refresh_sequencer #(
    parameter int unsigned         ROW_WIDTH   = 13,
    parameter int unsigned         BANK_WIDTH  = 3,
    parameter int unsigned         T_RESET_CYC = 40000,
    parameter int unsigned         T_CKE_CYC   = 100000,
    parameter int unsigned         T_XPR       = 72,
    parameter int unsigned         T_MRD       = 4,
    parameter int unsigned         T_MOD       = 12,
    parameter int unsigned         T_ZQINIT    = 512,
    parameter int unsigned         T_RP        = 6,
    parameter int unsigned         T_RFC       = 44,
    parameter int unsigned         T_REFI      = 3120,
    parameter logic [ROW_WIDTH-1:0] MR0        = '0,
    parameter logic [ROW_WIDTH-1:0] MR1        = '0,
    parameter logic [ROW_WIDTH-1:0] MR2        = '0,
    parameter logic [ROW_WIDTH-1:0] MR3        = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ddr3_init_refresh_sequencer_if.slave usr_io,
    output logic                       ddr_reset_n_o,
    output logic                       ddr_cke_o,
    output logic                       ddr_cs_n_o,
    output logic                       ddr_ras_n_o,
    output logic                       ddr_cas_n_o,
    output logic                       ddr_we_n_o,
    output logic                       ddr_odt_o,
    output logic [BANK_WIDTH-1:0]      ddr_ba_o,
    output logic [ROW_WIDTH-1:0]       ddr_addr_o,
    output logic                       init_done_o,
    output logic                       refresh_pending_o,
    output logic                       refresh_overrun_o
);
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MaxWait = max2(max2(max2(T_RESET_CYC, T_CKE_CYC), max2(T_XPR, T_MRD)),
                                           max2(max2(T_MOD, T_ZQINIT), max2(T_RP, T_RFC)));
    localparam int unsigned TimerW  = max2($clog2(MaxWait + 1), 1);
    localparam int unsigned RefW    = max2($clog2(T_REFI), 1);

    typedef enum logic [3:0] {
        StRstHold, StCkeWait, StXprWait, StMrsWait, StZqWait,
        StIdle, StDrain, StRpWait, StRfcWait
    } state_e;

    state_e                state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic [2:0]            mrs_cnt_q, mrs_cnt_d;
    logic [RefW-1:0]       ref_cnt_q, ref_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  reset_n_q, reset_n_d, cke_q, cke_d;
    logic                  cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
    logic                  odt_q, odt_d;
    logic [BANK_WIDTH-1:0] ba_q, ba_d, mrs_ba;
    logic [ROW_WIDTH-1:0]  addr_q, addr_d, mrs_val;
    logic                  timer_zero, ref_issue, ref_expire, usr_ready;

    // MRS order is MR2, MR3, MR1, MR0; BA carries the register index.
    always_comb begin
        mrs_ba  = '0;
        mrs_val = '0;
        unique case (mrs_cnt_q[1:0])
            2'd0: begin mrs_ba = BANK_WIDTH'(2); mrs_val = MR2; end
            2'd1: begin mrs_ba = BANK_WIDTH'(3); mrs_val = MR3; end
            2'd2: begin mrs_ba = BANK_WIDTH'(1); mrs_val = MR1; end
            2'd3: begin mrs_ba = BANK_WIDTH'(0); mrs_val = MR0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mrs_cnt_d   = mrs_cnt_q;
        init_done_d = init_done_q;
        reset_n_d   = reset_n_q;
        cke_d       = cke_q;
        cs_n_d      = 1'b0;
        ras_n_d     = 1'b1;
        cas_n_d     = 1'b1;
        we_n_d      = 1'b1;
        ba_d        = '0;
        addr_d      = '0;
        odt_d       = 1'b0;
        ref_issue   = 1'b0;
        usr_ready   = 1'b0;
        timer_zero  = (timer_q == '0);
        if (!timer_zero) timer_d = timer_q - TimerW'(1);

        unique case (state_q)
            StRstHold: begin
                cs_n_d = 1'b1;
                if (timer_zero) begin
                    state_d   = StCkeWait;
                    timer_d   = TimerW'(T_CKE_CYC - 1);
                    reset_n_d = 1'b1;
                end
            end
            StCkeWait: begin
                cs_n_d = !timer_zero;
                if (timer_zero) begin
                    state_d = StXprWait;
                    timer_d = TimerW'(T_XPR - 1);
                    cke_d   = 1'b1;
                end
            end
            StXprWait, StMrsWait: begin
                if (timer_zero) begin
                    if (mrs_cnt_q == 3'd4) begin
                        {ras_n_d, cas_n_d, we_n_d} = 3'b110;
                        addr_d[10] = 1'b1;
                        state_d    = StZqWait;
                        timer_d    = TimerW'(T_ZQINIT - 1);
                    end else begin
                        {ras_n_d, cas_n_d, we_n_d} = 3'b000;
                        ba_d      = mrs_ba;
                        addr_d    = mrs_val;
                        mrs_cnt_d = mrs_cnt_q + 3'd1;
                        state_d   = StMrsWait;
                        timer_d   = (mrs_cnt_q == 3'd3) ? TimerW'(T_MOD - 1) : TimerW'(T_MRD - 1);
                    end
                end
            end
            StZqWait: begin
                if (timer_zero) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                usr_ready = !pending_q;
                odt_d     = usr_io.odt;
                if (pending_q) begin
                    state_d = StDrain;
                end else if (usr_io.cmd_valid) begin
                    ras_n_d = usr_io.ras_n;
                    cas_n_d = usr_io.cas_n;
                    we_n_d  = usr_io.we_n;
                    ba_d    = usr_io.ba;
                    addr_d  = usr_io.addr;
                end
            end
            StDrain: begin
                if (usr_io.idle) begin
                    {ras_n_d, cas_n_d, we_n_d} = 3'b010;
                    addr_d[10] = 1'b1;
                    state_d    = StRpWait;
                    timer_d    = TimerW'(T_RP - 1);
                end
            end
            StRpWait: begin
                if (timer_zero) begin
                    {ras_n_d, cas_n_d, we_n_d} = 3'b001;
                    ref_issue = 1'b1;
                    state_d   = StRfcWait;
                    timer_d   = TimerW'(T_RFC - 1);
                end
            end
            StRfcWait: begin
                if (timer_zero) state_d = StIdle;
            end
            default: state_d = StRstHold;
        endcase
    end

    // A new expiry wins over the REF that clears the old one; no second refresh is queued.
    always_comb begin
        ref_expire = init_done_q && (ref_cnt_q == RefW'(T_REFI - 1));
        ref_cnt_d  = ref_cnt_q;
        if (init_done_q) ref_cnt_d = ref_expire ? '0 : ref_cnt_q + RefW'(1);
        pending_d  = ref_expire ? 1'b1 : (ref_issue ? 1'b0 : pending_q);
        overrun_d  = overrun_q | (ref_expire & pending_q & !ref_issue);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRstHold;
            timer_q     <= TimerW'(T_RESET_CYC - 1);
            mrs_cnt_q   <= '0;
            ref_cnt_q   <= '0;
            init_done_q <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            reset_n_q   <= 1'b0;
            cke_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            odt_q       <= 1'b0;
            ba_q        <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mrs_cnt_q   <= mrs_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            init_done_q <= init_done_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            reset_n_q   <= reset_n_d;
            cke_q       <= cke_d;
            cs_n_q      <= cs_n_d;
            ras_n_q     <= ras_n_d;
            cas_n_q     <= cas_n_d;
            we_n_q      <= we_n_d;
            odt_q       <= odt_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
        end
    end

    assign usr_io.cmd_ready  = usr_ready;
    assign ddr_reset_n_o     = reset_n_q;
    assign ddr_cke_o         = cke_q;
    assign ddr_cs_n_o        = cs_n_q;
    assign ddr_ras_n_o       = ras_n_q;
    assign ddr_cas_n_o       = cas_n_q;
    assign ddr_we_n_o        = we_n_q;
    assign ddr_odt_o         = odt_q;
    assign ddr_ba_o          = ba_q;
    assign ddr_addr_o        = addr_q;
    assign init_done_o       = init_done_q;
    assign refresh_pending_o = pending_q;
    assign refresh_overrun_o = overrun_q;
endmodule
